// File: rtl/spi_bit_down_counter_if.sv
// Control/status bundle for the SPI bit/frame down counter.
// master drives the controls; slave is the counter itself.
interface spi_bit_down_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             abort;
    logic             load;
    logic [WIDTH-1:0] datos;
    logic             ena;
    logic             auto_reload;
    logic [WIDTH-1:0] cuenta;
    logic             zero;
    logic             busy;
    logic             tc;

    modport master (
        output abort, load, datos, ena, auto_reload,
        input  cuenta, zero, busy, tc
    );

    modport slave (
        input  abort, load, datos, ena, auto_reload,
        output cuenta, zero, busy, tc
    );
endinterface

// File: rtl/spi_bit_down_counter.sv
// Loadable falling-edge down counter for SPI bit/frame counting, with abort,
// optional auto-reload from the last loaded value and a terminal-count pulse.
module spi_bit_down_counter #(
    parameter int unsigned     WIDTH       = 4,
    parameter logic [WIDTH-1:0] RELOAD_DFLT = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_bit_down_counter_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cuenta_q, cuenta_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             tc_q, tc_d;

    // Negedge keeps the count aligned with the SPI shift logic.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cuenta_q <= '0;
            period_q <= RELOAD_DFLT;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cuenta_q <= cuenta_d;
            period_q <= period_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cuenta_d = cuenta_q;
        period_d = period_q;
        tc_d     = 1'b0;

        if (bus.abort) begin
            cuenta_d = '0;
            state_d  = StIdle;
        end else if (bus.load) begin
            cuenta_d = bus.datos;
            period_d = bus.datos;
            state_d  = (bus.datos != '0) ? StRun : StIdle;
        end else if (bus.ena && (state_q == StRun)) begin
            if (cuenta_q > One) begin
                cuenta_d = cuenta_q - One;
            end else begin
                // RUN always holds a nonzero count, so this is the terminal edge.
                tc_d = 1'b1;
                if (bus.auto_reload) begin
                    cuenta_d = period_q;
                end else begin
                    cuenta_d = '0;
                    state_d  = StIdle;
                end
            end
        end
    end

    assign bus.cuenta = cuenta_q;
    assign bus.zero   = (cuenta_q == '0);
    assign bus.busy   = (state_q == StRun);
    assign bus.tc     = tc_q;
endmodule
